// File: rtl/snn_pkg.sv
// Constants and types shared by the SNN core and its input loader.
package snn_pkg;

    localparam int NUM_PIXELS = 784;
    localparam int NUM_HIDDEN = 32;
    localparam int NUM_OUT    = 10;
    localparam int BYTE_W     = 8;
    localparam int ADDR_W     = 10;
    localparam int NUM_BYTES  = NUM_PIXELS / BYTE_W;
    localparam int BYTE_CNT_W = $clog2(NUM_BYTES);

    typedef enum logic [1:0] {
        LOAD,
        ISSUE,
        WAIT_CORE
    } ld_state_t;

endpackage

// File: rtl/input_bit_ram.sv
// Byte-wide image store with a registered single-pixel read port.
// The store itself is never reset, so contents survive rst_n.
module input_bit_ram #(
    parameter int NUM_PIXELS = snn_pkg::NUM_PIXELS,
    parameter int BYTE_W     = snn_pkg::BYTE_W,
    parameter int ADDR_W     = snn_pkg::ADDR_W,
    parameter int NUM_BYTES  = NUM_PIXELS / BYTE_W,
    parameter int WADDR_W    = $clog2(NUM_BYTES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [WADDR_W-1:0] waddr,
    input  logic [BYTE_W-1:0]  wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic               q
);

    localparam int SEL_W = $clog2(BYTE_W);

    logic [BYTE_W-1:0]       mem [NUM_BYTES];
    logic [ADDR_W-SEL_W-1:0] rword;
    logic [SEL_W-1:0]        rbit;
    logic                    in_range;

    assign rword    = raddr[ADDR_W-1:SEL_W];
    assign rbit     = raddr[SEL_W-1:0];
    assign in_range = (raddr < ADDR_W'(NUM_PIXELS));

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Addresses past the image would index unused words, so they read as 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            q <= in_range ? mem[rword][rbit] : 1'b0;
        end
    end

endmodule

// File: rtl/snn_input_loader.sv
// Collects a packed binary image from the UART, starts the core once the
// image is complete and holds off new loads until the core reports done.
module snn_input_loader #(
    parameter int NUM_PIXELS = snn_pkg::NUM_PIXELS,
    parameter int BYTE_W     = snn_pkg::BYTE_W,
    parameter int ADDR_W     = snn_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_rdy,
    input  logic [BYTE_W-1:0] rx_data,
    output logic              clr_rx_rdy,
    input  logic [ADDR_W-1:0] addr_input_unit,
    output logic              q_input,
    output logic              start,
    input  logic              core_done,
    output logic              busy
);

    import snn_pkg::*;

    localparam int NUM_BYTES = NUM_PIXELS / BYTE_W;
    localparam int CNT_W     = $clog2(NUM_BYTES);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);

    ld_state_t        state;
    logic [CNT_W-1:0] byte_cnt;
    logic             wr_en;

    // A byte is consumed and acknowledged on the same edge, only while loading.
    assign wr_en      = rst_n && (state == LOAD) && rx_rdy;
    assign clr_rx_rdy = wr_en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= LOAD;
            byte_cnt <= '0;
            start    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            start <= 1'b0;
            unique case (state)
                LOAD: begin
                    if (rx_rdy) begin
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt <= '0;
                            state    <= ISSUE;
                            start    <= 1'b1;
                            busy     <= 1'b1;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    state <= WAIT_CORE;
                end
                WAIT_CORE: begin
                    if (core_done) begin
                        state <= LOAD;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

    input_bit_ram #(
        .NUM_PIXELS (NUM_PIXELS),
        .BYTE_W     (BYTE_W),
        .ADDR_W     (ADDR_W),
        .NUM_BYTES  (NUM_BYTES),
        .WADDR_W    (CNT_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_en),
        .waddr (byte_cnt),
        .wdata (rx_data),
        .raddr (addr_input_unit),
        .q     (q_input)
    );

endmodule
